// File: rtl/t_pulse_pkg.sv
// Shared types and defaults for the push-button to toggle-pulse front end.
package t_pulse_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_REPEAT_DELAY    = 8;
    localparam int DEF_REPEAT_PERIOD   = 4;

    // Counter width for a 0..v-1 range, never narrower than one bit.
    function automatic int clog2_min1(input int v);
        return (v > 2) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/sync2.sv
// Generic 1-bit two-flop synchronizer, async active-low reset to 0.
module sync2 (
    input  logic clk,
    input  logic n_rst,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/t_pulse_gen.sv
// Debounced push-button to one-cycle toggle pulse for a T flip-flop.
// Define T_PULSE_AUTOREPEAT_EN to add hold-to-repeat pulses.
module t_pulse_gen
    import t_pulse_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic n_rst,
    input  logic btn_in,
    output logic t_out,
    output logic pressed
);

    localparam int            CW      = clog2_min1(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          btn_s;
    state_t        state, nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          rep_fire;
    logic          pulse_nxt, pressed_nxt;

    sync2 u_sync (
        .clk   (clk),
        .n_rst (n_rst),
        .d     (btn_in),
        .q     (btn_s)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
        case (state)
            IDLE: begin
                if (btn_s) begin
                    nxt     = PRESS_CHK;
                    cnt_nxt = '0;
                end
            end
            PRESS_CHK: begin
                if (!btn_s)              nxt     = IDLE;
                else if (cnt == CNT_MAX) nxt     = HELD;
                else                     cnt_nxt = cnt + 1'b1;
            end
            HELD: begin
                if (!btn_s) begin
                    nxt     = REL_CHK;
                    cnt_nxt = '0;
                end
            end
            REL_CHK: begin
                if (btn_s)               nxt     = HELD;
                else if (cnt == CNT_MAX) nxt     = IDLE;
                else                     cnt_nxt = cnt + 1'b1;
            end
            default: nxt = IDLE;
        endcase
    end

`ifdef T_PULSE_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX) + 1;

    logic [RW-1:0] rcnt;
    logic          rfirst;

    // Counts only HELD cycles, so a release glitch pauses the cadence.
    assign rep_fire = (state == HELD) &&
                      (rcnt == (rfirst ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1)));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rcnt   <= '0;
            rfirst <= 1'b1;
        end else if (state == IDLE) begin
            rcnt   <= '0;
            rfirst <= 1'b1;
        end else if (state == HELD) begin
            if (rep_fire) begin
                rcnt   <= '0;
                rfirst <= 1'b0;
            end else begin
                rcnt   <= rcnt + 1'b1;
            end
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_comb begin
        pulse_nxt   = ((state == PRESS_CHK) && (nxt == HELD)) || rep_fire;
        pressed_nxt = (nxt == HELD) || (nxt == REL_CHK);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            t_out   <= 1'b0;
            pressed <= 1'b0;
        end else begin
            t_out   <= pulse_nxt;
            pressed <= pressed_nxt;
        end
    end

endmodule

// File: tb/tb_t_pulse_gen.sv
// Directed bench for t_pulse_gen driving a modelled toggle flop; pulse times are scoreboarded.
module tb_t_pulse_gen;
    import t_pulse_pkg::*;

    localparam int DC = 4;
    localparam int RD = 8;
    localparam int RP = 4;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic btn_in = 1'b0;
    logic t_out, pressed;
    logic q;
    logic t_prev = 1'b0;

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int exp_q[$];

    t_pulse_gen #(
        .DEBOUNCE_CYCLES (DC),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .btn_in  (btn_in),
        .t_out   (t_out),
        .pressed (pressed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream toggle flop on the same clock and reset.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst)     q <= 1'b0;
        else if (t_out) q <= ~q;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (n_rst && t_out) begin
            chk("t_consecutive", t_prev, 0);
            if (exp_q.size() == 0) chk("pulse_unexpected_cyc", cyc, 0);
            else                   chk("pulse_cyc", cyc, exp_q.pop_front());
        end
        t_prev <= t_out;
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic push_repeats(input int first, input int shift, input int last);
`ifdef T_PULSE_AUTOREPEAT_EN
        for (int t = first + RD + shift; t <= last; t += RP) exp_q.push_back(t);
`endif
    endtask

    // Raise the button at a negedge; first sampling edge is the next one.
    task automatic press_start(input int rel_at, input int shift);
        int   c0;
        int   p;
        logic qb;
        c0 = cyc;
        btn_in = 1'b1;
        p = c0 + DC + 3;
        exp_q.push_back(p);
        push_repeats(p, shift, rel_at + 3);
        wait_n(DC + 2);
        chk("press_pressed_early", pressed, 0);
        wait_n(1);
        chk("press_pressed_rise", pressed, 1);
        chk("press_t_out", t_out, 1);
        qb = q;
        wait_n(1);
        chk("q_toggle", q, !qb);
        chk("t_out_one_cycle", t_out, 0);
    endtask

    task automatic release_chk();
        btn_in = 1'b0;
        wait_n(DC + 2);
        chk("release_pressed_held", pressed, 1);
        wait_n(1);
        chk("release_pressed_fall", pressed, 0);
    endtask

    initial begin
        int rel;

        n_rst = 1'b0;
        btn_in = 1'b0;
        wait_n(3);
        chk("reset_t_out", t_out, 0);
        chk("reset_pressed", pressed, 0);
        n_rst = 1'b1;
        wait_n(3);
        chk("idle_pressed", pressed, 0);

        // Clean press, held 20 cycles.
        rel = cyc + 20;
        press_start(rel, 0);
        wait_until(rel);
        chk("clean_still_pressed", pressed, 1);
        release_chk();
        wait_n(4);
`ifndef T_PULSE_AUTOREPEAT_EN
        chk("clean_q", q, 1);
`endif

        // Bounce: 2 high, 1 low, 2 high, then low.
        btn_in = 1'b1; wait_n(2);
        btn_in = 1'b0; wait_n(1);
        btn_in = 1'b1; wait_n(2);
        btn_in = 1'b0;
        for (int i = 0; i < 12; i++) begin
            wait_n(1);
            chk("bounce_pressed", pressed, 0);
        end

        // Release glitch of 2 low cycles right after acceptance.
        rel = cyc + 40;
        press_start(rel, 2);
        btn_in = 1'b0; wait_n(2);
        btn_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wait_n(1);
            chk("glitch_pressed", pressed, 1);
        end
        wait_until(rel);
        release_chk();
        wait_n(4);
`ifndef T_PULSE_AUTOREPEAT_EN
        chk("glitch_q", q, 0);
`endif

        // Two presses chained into the toggle flop, 20 low cycles between.
        rel = cyc + 20;
        press_start(rel, 0);
`ifndef T_PULSE_AUTOREPEAT_EN
        chk("chain_q_first", q, 1);
`endif
        wait_until(rel);
        release_chk();
        wait_n(13);
        rel = cyc + 20;
        press_start(rel, 0);
`ifndef T_PULSE_AUTOREPEAT_EN
        chk("chain_q_second", q, 0);
`endif
        wait_until(rel);
        release_chk();
        wait_n(6);

        // Reset while in PRESS_CHK with the button still held.
        btn_in = 1'b1;
        wait_n(4);
        n_rst = 1'b0;
        #1;
        chk("midreset_t_out", t_out, 0);
        chk("midreset_pressed", pressed, 0);
        wait_n(1);
        n_rst = 1'b1;
        rel = cyc + 20;
        press_start(rel, 0);
        wait_until(rel);
        release_chk();
        wait_n(6);

`ifdef T_PULSE_AUTOREPEAT_EN
        // Hold-to-repeat for 40 cycles.
        rel = cyc + 40;
        press_start(rel, 0);
        wait_until(rel);
        release_chk();
        wait_n(6);
`endif

        wait_n(10);
        chk("pending_pulses", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
